uart_cmd_exec: RTL and testbench

Command executor between `UartSink` and `UartSource` in the UART host link. Consumes each 8-byte frame {opcode[15:0], address[15:0], data[31:0]} assembled by `UartSink`. Executes it against a single-port word memory and returns a response frame through `UartSource`. It is the first block that turns raw UART frames into memory-mapped accesses.

---
 rtl/uart_cmd_pkg.sv | 39 +++
 rtl/uart_cmd_decode.sv | 35 +++
 rtl/uart_cmd_exec.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_exec.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command executor:
//   - default frame field sizes (bytes) and helpers deriving bit offsets
//   - opcode constants (WRITE / READ / PING / ERR)
//   - FSM state encoding
// Frame layout, MSB first: {opcode, address, data}.
package uart_cmd_pkg;

  localparam int unsigned OPCDBYTE_DEF = 2;
  localparam int unsigned ADDRBYTE_DEF = 2;
  localparam int unsigned DATABYTE_DEF = 4;
  localparam int unsigned DEPTH_DEF    = 256;

  localparam logic [15:0] OP_WRITE = 16'h0001;
  localparam logic [15:0] OP_READ  = 16'h0002;
  localparam logic [15:0] OP_PING  = 16'h0003;
  localparam logic [15:0] OP_ERR   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RDREQ,
    ST_RDCAP,
    ST_SEND,
    ST_WAITTX
  } state_t;

  // Bit offset of the address field (data occupies the LSBs).
  function automatic int unsigned addr_lsb(input int unsigned databyte);
    return databyte * 8;
  endfunction

  // Bit offset of the opcode field (sits above address and data).
  function automatic int unsigned opcd_lsb(input int unsigned addrbyte,
                                           input int unsigned databyte);
    return (addrbyte + databyte) * 8;
  endfunction

endpackage

// File: rtl/uart_cmd_decode.sv
// uart_cmd_decode
// Combinational opcode/address classifier for a latched command frame.
// Ports:
//   opcode   in  OW : opcode field of the latched frame
//   addr     in  AW : address field of the latched frame
//   is_write out 1  : legal WRITE (address below DEPTH)
//   is_read  out 1  : legal READ  (address below DEPTH)
//   is_ping  out 1  : PING (address not checked)
//   is_err   out 1  : anything else, including out-of-range READ/WRITE
module uart_cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter int unsigned OW    = 16,
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic [OW-1:0] opcode,
  input  logic [AW-1:0] addr,
  output logic          is_write,
  output logic          is_read,
  output logic          is_ping,
  output logic          is_err
);

  logic addr_ok;

  always_comb begin
    addr_ok  = 64'(addr) < 64'(DEPTH);
    is_write = (opcode == OW'(OP_WRITE)) && addr_ok;
    is_read  = (opcode == OW'(OP_READ))  && addr_ok;
    is_ping  = (opcode == OW'(OP_PING));
    is_err   = !(is_write || is_read || is_ping);
  end

endmodule

// File: rtl/uart_cmd_exec.sv
// uart_cmd_exec
// Executes command frames from UartSink against a single-port word memory
// and returns a response frame through UartSource.
// Ports:
//   CLOCK     in  1        : clock
//   NRESET    in  1        : synchronous active-low reset
//   SINKDONE  in  1        : frame-valid pulse from UartSink
//   SINKDATA  in  BYTES*8  : frame {opcode, address, data}
//   FEN       out 1        : response-send pulse to UartSource
//   FDATA     out BYTES*8  : response frame
//   SRCDONE   in  1        : UartSource finished sending
//   MEMADDR   out ADDRBYTE*8 : memory word address (from latched frame)
//   MEMWDATA  out DATABYTE*8 : memory write data (from latched frame)
//   MEMWE     out 1        : write strobe
//   MEMRE     out 1        : read strobe
//   MEMRDATA  in  DATABYTE*8 : read data, valid the cycle after MEMRE
//   BUSY      out 1        : state is not IDLE
//   DROPPED   out 1        : a frame arriving while busy was discarded
// Configuration macro: UART_CMD_WRACK_EN -- when defined, a legal WRITE
// returns an acknowledge frame; otherwise it completes silently.
module uart_cmd_exec
  import uart_cmd_pkg::*;
#(
  parameter int unsigned OPCDBYTE = OPCDBYTE_DEF,
  parameter int unsigned ADDRBYTE = ADDRBYTE_DEF,
  parameter int unsigned DATABYTE = DATABYTE_DEF,
  parameter int unsigned BYTES    = OPCDBYTE + ADDRBYTE + DATABYTE,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                  CLOCK,
  input  logic                  NRESET,
  input  logic                  SINKDONE,
  input  logic [BYTES*8-1:0]    SINKDATA,
  output logic                  FEN,
  output logic [BYTES*8-1:0]    FDATA,
  input  logic                  SRCDONE,
  output logic [ADDRBYTE*8-1:0] MEMADDR,
  output logic [DATABYTE*8-1:0] MEMWDATA,
  output logic                  MEMWE,
  output logic                  MEMRE,
  input  logic [DATABYTE*8-1:0] MEMRDATA,
  output logic                  BUSY,
  output logic                  DROPPED
);

  localparam int unsigned OW    = OPCDBYTE * 8;
  localparam int unsigned AW    = ADDRBYTE * 8;
  localparam int unsigned DW    = DATABYTE * 8;
  localparam int unsigned FW    = BYTES * 8;
  localparam int unsigned A_LSB = addr_lsb(DATABYTE);
  localparam int unsigned O_LSB = opcd_lsb(ADDRBYTE, DATABYTE);

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q;
  logic [DW-1:0] rdata_q;
  logic [FW-1:0] fdata_q;
  logic          fen_q, memwe_q, memre_q, dropped_q;

  logic [OW-1:0] f_opcd;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic          is_write, is_read, is_ping, is_err;

  logic          frame_ld, rd_cap;
  logic          fen_d, memwe_d, memre_d, dropped_d;
  logic [FW-1:0] resp;

  assign f_opcd = frame_q[O_LSB +: OW];
  assign f_addr = frame_q[A_LSB +: AW];
  assign f_data = frame_q[0 +: DW];

  uart_cmd_decode #(
    .OW    (OW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_decode (
    .opcode   (f_opcd),
    .addr     (f_addr),
    .is_write (is_write),
    .is_read  (is_read),
    .is_ping  (is_ping),
    .is_err   (is_err)
  );

  // State register
  always_ff @(posedge CLOCK) begin
    if (!NRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (SINKDONE) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_read) begin
          state_d = ST_RDREQ;
        end else begin
`ifdef UART_CMD_WRACK_EN
          state_d = ST_SEND;
`else
          state_d = is_write ? ST_IDLE : ST_SEND;
`endif
        end
      end
      ST_RDREQ:  state_d = ST_RDCAP;
      ST_RDCAP:  state_d = ST_SEND;
      ST_SEND:   state_d = ST_WAITTX;
      // fen_q marks the first WAITTX cycle; SRCDONE seen there is ignored.
      ST_WAITTX: if (SRCDONE && !fen_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic. Strobes are computed one state early and registered so
  // that a reset edge cancels them and MEMWE lands at N+2 whether or not
  // the WRITE goes on to SEND.
  always_comb begin
    frame_ld  = (state_q == ST_IDLE) && SINKDONE;
    rd_cap    = (state_q == ST_RDCAP);
    memwe_d   = (state_q == ST_DECODE) && is_write;
    memre_d   = (state_q == ST_DECODE) && is_read;
    fen_d     = (state_q == ST_SEND);
    dropped_d = (state_q != ST_IDLE) && SINKDONE;
    BUSY      = (state_q != ST_IDLE);

    // PING echoes the frame verbatim.
    resp = frame_q;
    if (is_err)        resp = {OW'(OP_ERR),   f_addr, DW'(f_opcd)};
    else if (is_read)  resp = {OW'(OP_READ),  f_addr, rdata_q};
    else if (is_write) resp = {OW'(OP_WRITE), f_addr, f_data};
    else if (is_ping)  resp = frame_q;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      frame_q   <= '0;
      rdata_q   <= '0;
      fdata_q   <= '0;
      fen_q     <= 1'b0;
      memwe_q   <= 1'b0;
      memre_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      if (frame_ld) frame_q <= SINKDATA;
      if (rd_cap)   rdata_q <= MEMRDATA;
      if (fen_d)    fdata_q <= resp;
      fen_q     <= fen_d;
      memwe_q   <= memwe_d;
      memre_q   <= memre_d;
      dropped_q <= dropped_d;
    end
  end

  assign FEN      = fen_q;
  assign FDATA    = fdata_q;
  assign MEMADDR  = f_addr;
  assign MEMWDATA = f_data;
  assign MEMWE    = memwe_q;
  assign MEMRE    = memre_q;
  assign DROPPED  = dropped_q;

endmodule

// File: tb/tb_uart_cmd_exec.sv
// tb_uart_cmd_exec
// Scoreboard bench for uart_cmd_exec: expected responses, strobes and drop
// pulses (with their cycle numbers) are queued as frames are driven and
// checked as the DUT produces them. Includes a word memory and a UartSource
// responder that raises SRCDONE three cycles after FEN.
// Honours UART_CMD_WRACK_EN to match the DUT build.
module tb_uart_cmd_exec;

`ifdef UART_CMD_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif
  localparam int unsigned SRC_LAT = 3;

  logic        CLOCK = 1'b0;
  logic        NRESET;
  logic        SINKDONE;
  logic [63:0] SINKDATA;
  logic        FEN;
  logic [63:0] FDATA;
  logic        SRCDONE;
  logic [15:0] MEMADDR;
  logic [31:0] MEMWDATA;
  logic        MEMWE;
  logic        MEMRE;
  logic [31:0] MEMRDATA = '0;
  logic        BUSY;
  logic        DROPPED;

  uart_cmd_exec #(
    .OPCDBYTE (2),
    .ADDRBYTE (2),
    .DATABYTE (4),
    .DEPTH    (256)
  ) dut (
    .CLOCK    (CLOCK),
    .NRESET   (NRESET),
    .SINKDONE (SINKDONE),
    .SINKDATA (SINKDATA),
    .FEN      (FEN),
    .FDATA    (FDATA),
    .SRCDONE  (SRCDONE),
    .MEMADDR  (MEMADDR),
    .MEMWDATA (MEMWDATA),
    .MEMWE    (MEMWE),
    .MEMRE    (MEMRE),
    .MEMRDATA (MEMRDATA),
    .BUSY     (BUSY),
    .DROPPED  (DROPPED)
  );

  always #5 CLOCK = ~CLOCK;

  int unsigned cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] v;
    int unsigned c;
  } exp_t;

  exp_t        q_fen[$];
  exp_t        q_we[$];
  exp_t        q_re[$];
  int unsigned q_drop[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word memory
  logic [31:0] mem [0:255];
  always @(posedge CLOCK) begin
    if (MEMWE === 1'b1) mem[MEMADDR[7:0]] <= MEMWDATA;
    if (MEMRE === 1'b1) MEMRDATA <= mem[MEMADDR[7:0]];
  end

  // UartSource responder
  initial begin
    SRCDONE = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (FEN === 1'b1) begin
        repeat (SRC_LAT) @(posedge CLOCK);
        #1 SRCDONE = 1'b1;
        @(posedge CLOCK);
        #1 SRCDONE = 1'b0;
      end
    end
  end

  // Output monitor
  always @(negedge CLOCK) begin
    exp_t e;
    if (FEN === 1'b1) begin
      if (q_fen.size() > 0) begin
        e = q_fen.pop_front();
        check("fen_cycle", 64'(cyc), 64'(e.c));
        check("fdata", FDATA, e.v);
      end else check("fen_spurious", 64'(FEN), 64'd0);
    end
    if (MEMWE === 1'b1) begin
      if (q_we.size() > 0) begin
        e = q_we.pop_front();
        check("we_cycle", 64'(cyc), 64'(e.c));
        check("we_addr_data", 64'({MEMADDR, MEMWDATA}), e.v);
      end else check("we_spurious", 64'(MEMWE), 64'd0);
    end
    if (MEMRE === 1'b1) begin
      if (q_re.size() > 0) begin
        e = q_re.pop_front();
        check("re_cycle", 64'(cyc), 64'(e.c));
        check("re_addr", 64'(MEMADDR), e.v);
      end else check("re_spurious", 64'(MEMRE), 64'd0);
    end
    if (DROPPED === 1'b1) begin
      if (q_drop.size() > 0) check("drop_cycle", 64'(cyc), 64'(q_drop.pop_front()));
      else check("drop_spurious", 64'(DROPPED), 64'd0);
    end
  end

  task automatic step(input int unsigned k);
    repeat (k) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  // One-cycle SINKDONE pulse; n is the cycle in which it is sampled.
  task automatic pulse(input logic [63:0] f, output int unsigned n);
    SINKDATA = f;
    SINKDONE = 1'b1;
    n = cyc;
    step(1);
    SINKDONE = 1'b0;
  endtask

  task automatic wait_idle(output int unsigned fall);
    int unsigned i = 0;
    while (BUSY !== 1'b0 && i < 40) begin
      step(1);
      i++;
    end
    check("busy_bound", 64'(BUSY), 64'd0);
    fall = cyc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fen"},      64'(FEN),      64'd0);
    check({tag, "_fdata"},    FDATA,         64'd0);
    check({tag, "_memaddr"},  64'(MEMADDR),  64'd0);
    check({tag, "_memwdata"}, 64'(MEMWDATA), 64'd0);
    check({tag, "_memwe"},    64'(MEMWE),    64'd0);
    check({tag, "_memre"},    64'(MEMRE),    64'd0);
    check({tag, "_busy"},     64'(BUSY),     64'd0);
    check({tag, "_dropped"},  64'(DROPPED),  64'd0);
  endtask

  task automatic run(input logic [63:0] f, input bit has_fen, input logic [63:0] resp,
                     input int unsigned fen_lat, input bit we, input bit re,
                     input int unsigned fall_lat);
    int unsigned n, fall;
    exp_t e;
    n = cyc;
    if (has_fen) begin e.v = resp; e.c = n + fen_lat; q_fen.push_back(e); end
    if (we) begin e.v = 64'({f[47:32], f[31:0]}); e.c = n + 2; q_we.push_back(e); end
    if (re) begin e.v = 64'(f[47:32]); e.c = n + 2; q_re.push_back(e); end
    pulse(f, n);
    wait_idle(fall);
    check("busy_fall", 64'(fall), 64'(n + fall_lat));
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, m, fall;
    exp_t e;
    int unsigned wr_fall;
    wr_fall  = WRACK ? 7 : 2;
    NRESET   = 1'b0;
    SINKDONE = 1'b0;
    SINKDATA = '0;
    step(3);
    check_zero("reset");
    NRESET = 1'b1;
    step(2);

    // WRITE, READ back, boundary address 0xFF
    run(64'h0001_0010_DEADBEEF, WRACK, 64'h0001_0010_DEADBEEF, 3, 1'b1, 1'b0, wr_fall);
    run(64'h0002_0010_0000_0000, 1'b1, 64'h0002_0010_DEADBEEF, 5, 1'b0, 1'b1, 9);
    run(64'h0001_00FF_A5A55A5A, WRACK, 64'h0001_00FF_A5A55A5A, 3, 1'b1, 1'b0, wr_fall);
    run(64'h0002_00FF_1111_2222, 1'b1, 64'h0002_00FF_A5A55A5A, 5, 1'b0, 1'b1, 9);
    // PING echo and error responses
    run(64'h0003_1234_CAFEF00D, 1'b1, 64'h0003_1234_CAFEF00D, 3, 1'b0, 1'b0, 7);
    run(64'h0007_5555_12345678, 1'b1, 64'hFFFF_5555_00000007, 3, 1'b0, 1'b0, 7);
    run(64'h0002_0100_00000000, 1'b1, 64'hFFFF_0100_00000002, 3, 1'b0, 1'b0, 7);
    run(64'h0001_0100_12345678, 1'b1, 64'hFFFF_0100_00000001, 3, 1'b0, 1'b0, 7);
    run(64'h0000_0000_00000000, 1'b1, 64'hFFFF_0000_00000000, 3, 1'b0, 1'b0, 7);

    // Drops during WAITTX and coincident with SRCDONE, then accept
    pulse(64'h0003_0001_11111111, n);
    e.v = 64'h0003_0001_11111111; e.c = n + 3; q_fen.push_back(e);
    step(3);
    pulse(64'h0001_0020_BAD0BAD0, m);
    q_drop.push_back(m + 1);
    step(1);
    check("srcdone_at_drop2", 64'(SRCDONE), 64'd1);
    pulse(64'h0001_0021_BAD0BAD0, m);
    q_drop.push_back(m + 1);
    check("busy_low_at_accept", 64'(BUSY), 64'd0);
    check("accept_cycle", 64'(cyc), 64'(n + 7));
    pulse(64'h0003_0002_22222222, m);
    e.v = 64'h0003_0002_22222222; e.c = m + 3; q_fen.push_back(e);
    wait_idle(fall);
    check("busy_fall_after_drop", 64'(fall), 64'(m + 7));
    step(2);

    // Reset at N+3 of a READ, with a coincident SINKDONE
    e.v = 64'h0000_0000_0000_0010; e.c = cyc + 2; q_re.push_back(e);
    pulse(64'h0002_0010_0000_0000, n);
    step(2);
    NRESET = 1'b0;
    pulse(64'h0003_4444_55556666, m);
    NRESET = 1'b1;
    check_zero("midreset");
    step(8);
    check("busy_after_reset", 64'(BUSY), 64'd0);

    // Recovery
    run(64'h0003_ABCD_01234567, 1'b1, 64'h0003_ABCD_01234567, 3, 1'b0, 1'b0, 7);

    check("fen_queue_left",  64'(q_fen.size()),  64'd0);
    check("we_queue_left",   64'(q_we.size()),   64'd0);
    check("re_queue_left",   64'(q_re.size()),   64'd0);
    check("drop_queue_left", 64'(q_drop.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
